rx_chksum_chk: RTL and testbench

Receive-side checksum checker for the DM9000A Ethernet path. It accepts a byte stream from the RX frame reader and writes each byte into the packet dual-port RAM through port A. While writing, it accumulates the 16-bit one's-complement sum over the same bytes. At end of frame it reports the folded sum and a pass flag, which the UDP/IP RX control logic consumes before releasing the buffer.

---
 rtl/chksum_pkg.sv | 18 +
 rtl/ones_comp_acc.sv | 32 +++
 rtl/rx_chksum_chk.sv | 162 ++++++++++++++++
 tb/tb_rx_chksum_chk.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/chksum_pkg.sv
// Shared definitions for the DM9000A receive checksum checker: FSM encoding,
// the passing checksum value and default port widths.
package chksum_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 16;

  localparam logic [15:0] CHKSUM_OK = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_FOLD1 = 3'd2,
    ST_FOLD2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ones_comp_acc.sv
// 32-bit one's-complement accumulator: adds 16-bit words, then folds the
// upper half back into the lower half on request.
module ones_comp_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add_en,
  input  logic [15:0] word,
  input  logic        fold,
  output logic [31:0] sum
);

  logic [31:0] sum_r;

  // Accumulator register; clear wins over fold, fold wins over add
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= 32'h0000_0000;
    end else if (clear) begin
      sum_r <= 32'h0000_0000;
    end else if (fold) begin
      sum_r <= {16'h0000, sum_r[15:0]} + {16'h0000, sum_r[31:16]};
    end else if (add_en) begin
      sum_r <= sum_r + {16'h0000, word};
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/rx_chksum_chk.sv
// Receive checksum checker: writes RX bytes into DPRAM port A while summing them.
// Build macro RX_CHKSUM_STORE_EN enables the DPRAM write path; otherwise port A is tied to 0.
module rx_chksum_chk
  import chksum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              iDm9000aClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBaseAddr,
  input  logic [LEN_W-1:0]  iLen,
  input  logic              iByteValid,
  input  logic [7:0]        iByte,
  output logic              oByteReady,
  output logic              wren_a,
  output logic [ADDR_W-1:0] address_a,
  output logic [7:0]        data_a,
  output logic [15:0]       oChecksum,
  output logic              oChkOk,
  output logic              oBusy,
  output logic              oRunEnd
);

  state_t            state_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  count_r;
  logic [7:0]        hi_r;

  logic              start_s;
  logic              accept_s;
  logic              last_s;
  logic              add_en_s;
  logic              fold_s;
  logic [LEN_W:0]    count_inc_s;
  logic [15:0]       word_s;
  logic [15:0]       fold_val_s;
  logic [31:0]       sum_s;

  // Handshake, word assembly and fold decode
  always_comb begin
    start_s     = iStart && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    accept_s    = iByteValid && oByteReady;
    count_inc_s = {1'b0, count_r} + {{LEN_W{1'b0}}, 1'b1};
    last_s      = (count_inc_s == {1'b0, len_r});
    add_en_s    = accept_s && (count_r[0] || last_s);
    fold_s      = (state_r == ST_FOLD1) || (state_r == ST_FOLD2);
    // A trailing odd byte is padded with a zero low byte
    if (count_r[0]) begin
      word_s = {hi_r, iByte};
    end else begin
      word_s = {iByte, 8'h00};
    end
    // After the first fold the sum fits 17 bits, so a 16-bit wrap add finishes it
    fold_val_s = sum_s[15:0] + sum_s[31:16];
  end

  ones_comp_acc u_acc (
    .clk    (iDm9000aClk),
    .rst    (iRst),
    .clear  (start_s),
    .add_en (add_en_s),
    .word   (word_s),
    .fold   (fold_s),
    .sum    (sum_s)
  );

  // Frame FSM with registered status outputs
  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      state_r    <= ST_IDLE;
      len_r      <= {LEN_W{1'b0}};
      count_r    <= {LEN_W{1'b0}};
      hi_r       <= 8'h00;
      oByteReady <= 1'b0;
      oChecksum  <= 16'h0000;
      oChkOk     <= 1'b0;
      oBusy      <= 1'b0;
      oRunEnd    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            len_r     <= iLen;
            count_r   <= {LEN_W{1'b0}};
            hi_r      <= 8'h00;
            oChecksum <= 16'h0000;
            oChkOk    <= 1'b0;
            oRunEnd   <= 1'b0;
            oBusy     <= 1'b1;
            if (iLen != {LEN_W{1'b0}}) begin
              state_r    <= ST_RECV;
              oByteReady <= 1'b1;
            end else begin
              state_r    <= ST_FOLD1;
              oByteReady <= 1'b0;
            end
          end
        end
        ST_RECV: begin
          if (accept_s) begin
            count_r <= count_inc_s[LEN_W-1:0];
            if (!count_r[0]) begin
              hi_r <= iByte;
            end
            if (last_s) begin
              state_r    <= ST_FOLD1;
              oByteReady <= 1'b0;
            end
          end
        end
        ST_FOLD1: begin
          state_r <= ST_FOLD2;
        end
        ST_FOLD2: begin
          oChecksum <= fold_val_s;
          oChkOk    <= (fold_val_s == CHKSUM_OK);
          oRunEnd   <= 1'b1;
          oBusy     <= 1'b0;
          state_r   <= ST_DONE;
        end
        default: begin
          state_r    <= ST_IDLE;
          oByteReady <= 1'b0;
          oBusy      <= 1'b0;
          oRunEnd    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RX_CHKSUM_STORE_EN
  logic [ADDR_W-1:0] base_r;

  // DPRAM port A: one registered write per accepted byte
  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      base_r    <= {ADDR_W{1'b0}};
      wren_a    <= 1'b0;
      address_a <= {ADDR_W{1'b0}};
      data_a    <= 8'h00;
    end else begin
      if (start_s) begin
        base_r <= iBaseAddr;
      end
      wren_a <= accept_s;
      if (accept_s) begin
        address_a <= base_r + count_r[ADDR_W-1:0];
        data_a    <= iByte;
      end
    end
  end
`else
  logic unused_base_s;
  assign unused_base_s = ^iBaseAddr;
  assign wren_a        = 1'b0;
  assign address_a     = {ADDR_W{1'b0}};
  assign data_a        = 8'h00;
`endif

endmodule

// File: tb/tb_rx_chksum_chk.sv
// Directed self-checking bench for rx_chksum_chk; write checks follow RX_CHKSUM_STORE_EN.
module tb_rx_chksum_chk;

  logic        iDm9000aClk = 1'b0;
  logic        iRst        = 1'b1;
  logic        iStart      = 1'b0;
  logic [9:0]  iBaseAddr   = 10'd0;
  logic [15:0] iLen        = 16'd0;
  logic        iByteValid  = 1'b0;
  logic [7:0]  iByte       = 8'h00;
  logic        oByteReady;
  logic        wren_a;
  logic [9:0]  address_a;
  logic [7:0]  data_a;
  logic [15:0] oChecksum;
  logic        oChkOk;
  logic        oBusy;
  logic        oRunEnd;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] fb [0:19];
  logic [9:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

`ifdef RX_CHKSUM_STORE_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  rx_chksum_chk dut (
    .iDm9000aClk (iDm9000aClk),
    .iRst        (iRst),
    .iStart      (iStart),
    .iBaseAddr   (iBaseAddr),
    .iLen        (iLen),
    .iByteValid  (iByteValid),
    .iByte       (iByte),
    .oByteReady  (oByteReady),
    .wren_a      (wren_a),
    .address_a   (address_a),
    .data_a      (data_a),
    .oChecksum   (oChecksum),
    .oChkOk      (oChkOk),
    .oBusy       (oBusy),
    .oRunEnd     (oRunEnd)
  );

  always #5 iDm9000aClk = ~iDm9000aClk;

  // Record every DPRAM write, sampled mid-cycle
  always @(negedge iDm9000aClk) begin
    if (wren_a) begin
      wr_addr_q.push_back(address_a);
      wr_data_q.push_back(data_a);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"},  {31'd0, oByteReady}, 32'd0);
    check_eq({tag, "_wren"},   {31'd0, wren_a},     32'd0);
    check_eq({tag, "_addr"},   {22'd0, address_a},  32'd0);
    check_eq({tag, "_data"},   {24'd0, data_a},     32'd0);
    check_eq({tag, "_chksum"}, {16'd0, oChecksum},  32'd0);
    check_eq({tag, "_ok"},     {31'd0, oChkOk},     32'd0);
    check_eq({tag, "_busy"},   {31'd0, oBusy},      32'd0);
    check_eq({tag, "_runend"}, {31'd0, oRunEnd},    32'd0);
  endtask

  // Runs one frame from fb[], called and returning at a negedge
  task automatic run_frame(input string tag, input logic [9:0] base, input int len,
                           input bit stall, input logic [15:0] exp_sum, input logic exp_ok);
    int start_wr;
    int idx;
    int cyc;
    int nwr;
    logic acc;
    logic [9:0] ea;
    start_wr   = wr_addr_q.size();
    iBaseAddr  = base;
    iLen       = len[15:0];
    iStart     = 1'b1;
    @(negedge iDm9000aClk);
    iStart = 1'b0;
    check_eq({tag, "_busy_start"}, {31'd0, oBusy}, 32'd1);
    check_eq({tag, "_ready_start"}, {31'd0, oByteReady}, (len != 0) ? 32'd1 : 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 400) begin
      iByteValid = stall ? (cyc % 2 == 0) : 1'b1;
      iByte      = fb[idx];
      acc        = iByteValid && oByteReady;
      @(negedge iDm9000aClk);
      if (acc) idx++;
      cyc++;
    end
    iByteValid = 1'b0;
    check_eq({tag, "_accepted"}, idx, len);
    // FOLD1
    check_eq({tag, "_ready_f1"},  {31'd0, oByteReady}, 32'd0);
    check_eq({tag, "_runend_f1"}, {31'd0, oRunEnd},    32'd0);
    @(negedge iDm9000aClk);
    // FOLD2
    check_eq({tag, "_runend_f2"}, {31'd0, oRunEnd}, 32'd0);
    check_eq({tag, "_busy_f2"},   {31'd0, oBusy},   32'd1);
    @(negedge iDm9000aClk);
    // DONE
    check_eq({tag, "_runend"}, {31'd0, oRunEnd},   32'd1);
    check_eq({tag, "_busy"},   {31'd0, oBusy},     32'd0);
    check_eq({tag, "_chksum"}, {16'd0, oChecksum}, {16'd0, exp_sum});
    check_eq({tag, "_ok"},     {31'd0, oChkOk},    {31'd0, exp_ok});
    nwr = wr_addr_q.size() - start_wr;
    if (STORE) begin
      check_eq({tag, "_nwr"}, nwr, len);
      for (int i = 0; i < len && i < nwr; i++) begin
        ea = base + 10'(i);
        check_eq({tag, "_waddr"}, {22'd0, wr_addr_q[start_wr + i]}, {22'd0, ea});
        check_eq({tag, "_wdata"}, {24'd0, wr_data_q[start_wr + i]}, {24'd0, fb[i]});
      end
    end else begin
      check_eq({tag, "_nwr"}, nwr, 0);
    end
  endtask

  initial begin
    int nwr;
    repeat (2) @(negedge iDm9000aClk);
    check_idle_outputs("reset");
    iRst = 1'b0;
    @(negedge iDm9000aClk);

    fb = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
           8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    run_frame("ipv4", 10'd0, 20, 1'b0, 16'hFFFF, 1'b1);

    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    run_frame("odd3", 10'd0, 3, 1'b0, 16'h0402, 1'b0);

    fb[0] = 8'hFF; fb[1] = 8'hFF; fb[2] = 8'hFF; fb[3] = 8'hFF;
    run_frame("carry", 10'd0, 4, 1'b0, 16'hFFFF, 1'b1);

    // A1B2 + C3D4 = 1_6586 -> 6587
    fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3; fb[3] = 8'hD4;
    run_frame("wrap", 10'd1022, 4, 1'b1, 16'h6587, 1'b0);

    run_frame("zero", 10'd5, 0, 1'b0, 16'h0000, 1'b0);

    // Abort after two of ten bytes; the third accept coincides with reset
    nwr       = wr_addr_q.size();
    iBaseAddr = 10'd100;
    iLen      = 16'd10;
    iStart    = 1'b1;
    @(negedge iDm9000aClk);
    iStart     = 1'b0;
    iByteValid = 1'b1;
    iByte      = 8'h11;
    @(negedge iDm9000aClk);
    iByte = 8'h22;
    @(negedge iDm9000aClk);
    iByte = 8'h33;
    iRst  = 1'b1;
    @(negedge iDm9000aClk);
    check_idle_outputs("abort");
    iRst       = 1'b0;
    iByteValid = 1'b0;
    repeat (3) @(negedge iDm9000aClk);
    check_eq("abort_busy_after", {31'd0, oBusy}, 32'd0);
    check_eq("abort_ready_after", {31'd0, oByteReady}, 32'd0);
    if (STORE) begin
      check_eq("abort_nwr", wr_addr_q.size() - nwr, 2);
      check_eq("abort_waddr1", {22'd0, wr_addr_q[nwr + 1]}, 32'd101);
      check_eq("abort_wdata1", {24'd0, wr_data_q[nwr + 1]}, 32'h22);
    end else begin
      check_eq("abort_nwr", wr_addr_q.size() - nwr, 0);
    end

    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    run_frame("post_abort", 10'd7, 3, 1'b0, 16'h0402, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
